noc_resp_tx: RTL and testbench

Response-side transmitter for the NoC byte bus. It accepts one READ_RESPONSE or WRITE_RESPONSE request at a time and serializes it onto the 9-bit {ALE_WRITE, CMD_WRITE} bus as command word, return-ID byte, payload bytes and END word. Idle cycles carry the IDLE command word. It is the counterpart of the NoC command receiver, which decodes the same 4-bit {ALE, code} encoding on {ALE_READ, CMD_READ}.

---
 rtl/noc_pkg.sv | 28 ++
 rtl/noc_resp_tx.sv | 145 ++++++++++++++
 tb/tb_noc_resp_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC byte-bus encodings used by the command receiver and the
// response transmitter.
package noc_pkg;

  typedef enum logic [3:0] {
    NOC_IDLE       = 4'b1_000,
    NOC_READ       = 4'b1_001,
    NOC_READ_RESP  = 4'b1_010,
    NOC_WRITE      = 4'b1_011,
    NOC_WRITE_RESP = 4'b1_100,
    NOC_RESERVED   = 4'b1_101,
    NOC_MESSAGE    = 4'b1_110,
    NOC_END        = 4'b1_111
  } noc_code_e;

  localparam logic [8:0] NOC_WORD_IDLE = 9'h100;
  localparam logic [8:0] NOC_WORD_END  = 9'h1E0;

  // Bit 4 of a command word is reserved and always driven low.
  function automatic logic [8:0] noc_cmd_word(
    input noc_code_e  code,
    input logic       err,
    input logic [2:0] err_code
  );
    return {code, 1'b0, err, err_code};
  endfunction

endpackage

// File: rtl/noc_resp_tx.sv
// Serializes READ/WRITE responses onto the 9-bit {ALE_WRITE, CMD_WRITE}
// bus: command, return ID, payload, END; IDLE words otherwise.
module noc_resp_tx
  import noc_pkg::*;
#(
  parameter int unsigned IDLE_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_type,
  input  logic [7:0] req_return_id,
  input  logic       req_err,
  input  logic [2:0] req_err_code,
  input  logic [7:0] req_len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] CMD_WRITE,
  output logic       ALE_WRITE,
  output logic       busy,
  output logic       pkt_done,
  output logic       err_abort
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_END
  } tx_state_e;

  localparam logic [3:0] STALL_MAX = 4'(IDLE_LIMIT);

  tx_state_e  state_q, state_d;
  logic [8:0] bus_q, bus_d;
  logic [7:0] id_q, id_d;
  logic [7:0] len_q, len_d;
  logic       type_q, type_d;
  logic [7:0] rem_q, rem_d;
  logic [3:0] stall_q, stall_d;
  logic       pkt_done_q, pkt_done_d;
  logic       err_abort_q, err_abort_d;
  noc_code_e  req_code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bus_q       <= NOC_WORD_IDLE;
      id_q        <= '0;
      len_q       <= '0;
      type_q      <= 1'b0;
      rem_q       <= '0;
      stall_q     <= '0;
      pkt_done_q  <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      id_q        <= id_d;
      len_q       <= len_d;
      type_q      <= type_d;
      rem_q       <= rem_d;
      stall_q     <= stall_d;
      pkt_done_q  <= pkt_done_d;
      err_abort_q <= err_abort_d;
    end
  end

  always_comb begin
    req_code = NOC_READ_RESP;
    if (req_type) begin
      req_code = NOC_WRITE_RESP;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_d       = NOC_WORD_IDLE;
    id_d        = id_q;
    len_d       = len_q;
    type_d      = type_q;
    rem_d       = rem_q;
    stall_d     = stall_q;
    pkt_done_d  = 1'b0;
    err_abort_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          bus_d   = noc_cmd_word(req_code, req_err, req_err_code);
          id_d    = req_return_id;
          len_d   = req_len;
          type_d  = req_type;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        bus_d   = {1'b0, id_q};
        rem_d   = len_q;
        stall_d = '0;
        if (!type_q && len_q != 8'd0) begin
          state_d = S_DATA;
        end else begin
          state_d = S_END;
        end
      end
      S_DATA: begin
        if (data_valid) begin
          bus_d   = {1'b0, data_in};
          rem_d   = rem_q - 8'd1;
          stall_d = '0;
          if (rem_q == 8'd1) begin
            state_d = S_END;
          end
        end else if (stall_q < STALL_MAX) begin
          stall_d = stall_q + 4'd1;
        end else begin
          // Upstream flushes the rest of the payload from its FIFO.
          bus_d       = NOC_WORD_END;
          err_abort_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_END: begin
        bus_d      = NOC_WORD_END;
        pkt_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign data_ready = (state_q == S_DATA);
  assign busy       = (state_q != S_IDLE);
  assign ALE_WRITE  = bus_q[8];
  assign CMD_WRITE  = bus_q[7:0];
  assign pkt_done   = pkt_done_q;
  assign err_abort  = err_abort_q;

endmodule

// File: tb/tb_noc_resp_tx.sv
// Directed vector bench for noc_resp_tx.
module tb_noc_resp_tx;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_type;
  logic [7:0] req_return_id;
  logic       req_err;
  logic [2:0] req_err_code;
  logic [7:0] req_len;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] CMD_WRITE;
  logic       ALE_WRITE;
  logic       busy;
  logic       pkt_done;
  logic       err_abort;

  int n_cmp;
  int n_bad;

  noc_resp_tx #(.IDLE_LIMIT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_type     (req_type),
    .req_return_id(req_return_id),
    .req_err      (req_err),
    .req_err_code (req_err_code),
    .req_len      (req_len),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .CMD_WRITE    (CMD_WRITE),
    .ALE_WRITE    (ALE_WRITE),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .err_abort    (err_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic       rt;
    logic [7:0] id;
    logic       err;
    logic [2:0] ec;
    logic [7:0] len;
    logic [7:0] din;
    logic       dv;
    logic [8:0] bus;
    logic       rdy;
    logic       dr;
    logic       bsy;
    logic       pd;
    logic       ea;
  } vec_t;

  vec_t vecs[$];

  task automatic add(
    input logic rv, input logic rt, input logic [7:0] id,
    input logic err, input logic [2:0] ec, input logic [7:0] len,
    input logic [7:0] din, input logic dv, input logic [8:0] bus,
    input logic rdy, input logic dr, input logic bsy,
    input logic pd, input logic ea
  );
    vec_t v;
    v.rv = rv; v.rt = rt; v.id = id; v.err = err; v.ec = ec;
    v.len = len; v.din = din; v.dv = dv; v.bus = bus;
    v.rdy = rdy; v.dr = dr; v.bsy = bsy; v.pd = pd; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic check(
    input string name, input logic [8:0] bus, input logic rdy,
    input logic dr, input logic bsy, input logic pd, input logic ea
  );
    logic [13:0] act, exp;
    act = {ALE_WRITE, CMD_WRITE, req_ready, data_ready, busy,
           pkt_done, err_abort};
    exp = {bus, rdy, dr, bsy, pd, ea};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got bus=%h rdy/dr/busy/pd/ea=%b want bus=%h %b",
               name, act[13:5], act[4:0], exp[13:5], exp[4:0]);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid     = v.rv;
    req_type      = v.rt;
    req_return_id = v.id;
    req_err       = v.err;
    req_err_code  = v.ec;
    req_len       = v.len;
    data_in       = v.din;
    data_valid    = v.dv;
  endtask

  task automatic step(input logic rv, input logic rt, input logic [7:0] id,
                      input logic [7:0] len, input logic [7:0] din,
                      input logic dv);
    vec_t v;
    v.rv = rv; v.rt = rt; v.id = id; v.err = 1'b0; v.ec = 3'd0;
    v.len = len; v.din = din; v.dv = dv;
    v.bus = '0; v.rdy = 0; v.dr = 0; v.bsy = 0; v.pd = 0; v.ea = 0;
    drive(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    req_valid = 0; req_type = 0; req_return_id = '0; req_err = 0;
    req_err_code = '0; req_len = '0; data_in = '0; data_valid = 0;

    // Reset state
    #12;
    check("reset_hold", 9'h100, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 9'h100, 1, 0, 0, 0, 0);

    // Read response, id 5A, len 3
    add(1,0,8'h5A,0,3'd0,8'd3,8'h00,0, 9'h140, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h00,0, 9'h05A, 0,1,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'hA1,1, 9'h0A1, 0,1,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'hA2,1, 9'h0A2, 0,1,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'hA3,1, 9'h0A3, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'hEE,1, 9'h1E0, 1,0,0,1,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'hEE,1, 9'h100, 1,0,0,0,0);
    // Write response with error, data_valid held high
    add(1,1,8'h07,1,3'b101,8'd9,8'h55,1, 9'h18D, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h55,1, 9'h007, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h55,1, 9'h1E0, 1,0,0,1,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h55,0, 9'h100, 1,0,0,0,0);
    // Read len 2 with a 4-cycle stall
    add(1,0,8'h42,0,3'd0,8'd2,8'h00,0, 9'h140, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h00,0, 9'h042, 0,1,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'hB0,1, 9'h0B0, 0,1,1,0,0);
    for (int i = 0; i < 4; i++)
      add(0,0,8'h00,0,3'd0,8'd0,8'h00,0, 9'h100, 0,1,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'hB1,1, 9'h0B1, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h00,0, 9'h1E0, 1,0,0,1,0);
    // Back-to-back writes, req_valid held; id captured only on accept
    add(1,1,8'h11,0,3'd0,8'd0,8'h00,0, 9'h180, 0,0,1,0,0);
    add(1,1,8'h22,0,3'd2,8'd0,8'h00,0, 9'h011, 0,0,1,0,0);
    add(1,1,8'h22,0,3'd2,8'd0,8'h00,0, 9'h1E0, 1,0,0,1,0);
    add(1,1,8'h22,0,3'd2,8'd0,8'h00,0, 9'h182, 0,0,1,0,0);
    add(0,0,8'h99,0,3'd0,8'd0,8'h00,0, 9'h022, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h00,0, 9'h1E0, 1,0,0,1,0);
    // Read with len 0 has no payload
    add(1,0,8'h3C,0,3'd1,8'd0,8'h77,1, 9'h141, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h77,1, 9'h03C, 0,0,1,0,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h77,1, 9'h1E0, 1,0,0,1,0);
    add(0,0,8'h00,0,3'd0,8'd0,8'h77,0, 9'h100, 1,0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].bus, vecs[i].rdy,
            vecs[i].dr, vecs[i].bsy, vecs[i].pd, vecs[i].ea);
    end

    // Stall abort: one byte then data stops
    step(1, 0, 8'h33, 8'd4, 8'h00, 0);
    check("abort_cmd", 9'h140, 0, 0, 1, 0, 0);
    step(0, 0, 8'h00, 8'd0, 8'h00, 0);
    check("abort_id", 9'h033, 0, 1, 1, 0, 0);
    step(0, 0, 8'h00, 8'd0, 8'hC0, 1);
    check("abort_b0", 9'h0C0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 8'h00, 8'd0, 8'h00, 0);
      check($sformatf("abort_idle%0d", i), 9'h100, 0, 1, 1, 0, 0);
    end
    step(0, 0, 8'h00, 8'd0, 8'h00, 0);
    check("abort_end", 9'h1E0, 1, 0, 0, 0, 1);
    step(0, 0, 8'h00, 8'd0, 8'h00, 0);
    check("abort_after", 9'h100, 1, 0, 0, 0, 0);

    // Asynchronous reset during payload
    step(1, 0, 8'h44, 8'd3, 8'h00, 0);
    step(0, 0, 8'h00, 8'd0, 8'h00, 0);
    step(0, 0, 8'h00, 8'd0, 8'hD0, 1);
    check("midrst_pre", 9'h0D0, 0, 1, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_async", 9'h100, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 8'h00, 8'd0, 8'hD1, 1);
    check("midrst_after", 9'h100, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
